mpi_bus_master: RTL and testbench
=================================

// Module: mpi_bus_master
// PURPOSE
//  Parametrised MPI (multiplexed address/data) bus cycle sequencer for the next-generation VM2-class core.
//  Turns one request from the CPU control FSM into a full bus cycle: DATI, DATO, DATOB, DATIO (read-modify-write) or IAK.
//  Cycles use the SYNC/DIN/DOUT/RPLY handshake. Also arbitrates DMA ownership via DMR/DMGO/SACK.
//  Sits between the CPU microsequencer and the tri-state AD pads.
// PARAMETERS
//  AW       16   address width driven in the address phase (AW <= DW)
//  DW       16   data width; AD bus width
//  SETUP    1    address-setup cycles before SYNC rises (1..15)
//  TMO_CYC  255  RPLY timeout in clocks, used only with MPI_TIMEOUT_EN (1..2^16-1)
// PORTS
//  clk        in   1    system clock; all state changes on rising edge
//  rst_n      in   1    synchronous active-low reset
//  req        in   1    request valid; held by requester until ack
//  req_op     in   3    000 DATI, 001 DATO, 010 DATOB, 011 DATIO, 100 IAK, others illegal
//  req_addr   in   AW   bus address
//  req_wdata  in   DW   write data; byte data already on the lane selected by addr[0]
//  ack        out  1    one-cycle completion pulse
//  err        out  1    valid with ack: timeout or illegal op
//  rdata      out  DW   read data; valid with ack, held until next ack
//  ad_o       out  DW   AD output value
//  ad_oe      out  1    AD output enable; pad drives ad_o when 1
//  ad_i       in   DW   AD input value
//  sync/din/dout/wtbt/iako  out 1  bus strobes, active high
//  rply       in   1    slave reply
//  dmr        in   1    DMA request
//  sack       in   1    DMA select acknowledge
//  dmgo       out  1    DMA grant
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, rdata 0. Reset mid-cycle drops every strobe and ad_oe on that edge; no ack is issued.
//  IDLE
//   - dmr=1 -> DGNT (dmr beats req on the same edge; req stays pending).
//   - else req=1 and op legal -> ADDR.
//   - else req=1 and op illegal -> ack=1, err=1 next cycle; stay in IDLE.
//  ADDR (SETUP cycles)
//   - ad_oe=1, ad_o = zero-extended addr (0 for IAK).
//   - wtbt=1 for DATO/DATOB/DATIO; 0 for DATI/IAK.
//  SYNC (1 cycle)
//   - sync=1; address still driven.
//  DATA
//   - Read ops: ad_oe=0, din=1 (plus iako=1 for IAK).
//   - Write ops: ad_oe=1, ad_o=wdata, dout=1, wtbt=1 only for DATOB.
//   - sync stays 1 through DATA/RWAIT.
//   - First cycle with rply=1: rdata<=ad_i (reads), din/dout/iako drop -> RWAIT.
//  RWAIT
//   - Wait rply=0.
//   - DATIO after read phase -> DATA as write phase: dout, wdata, wtbt=0, sync held.
//   - Otherwise -> END.
//  END: sync=0, ad_oe=0, ack=1 (err=0) -> IDLE. Latency with SETUP=1 and immediate rply: 5 clocks from req to ack (DATIO: 7).
//  DGNT: dmgo=1 until sack=1 -> DMA (dmgo=0, all bus outputs released). Return to IDLE when sack=0.
//  rply is used as sampled (the board synchroniser is external). A rply that is still high on entry to DATA is ignored until it has been seen low once.
// CONFIGURATION
//  MPI_TIMEOUT_EN defined
//   - 16-bit counter clears on DATA entry, increments each DATA/RWAIT cycle.
//   - At count==TMO_CYC: all strobes and ad_oe drop, ack=1, err=1, rdata unchanged, FSM -> IDLE.
//  MPI_TIMEOUT_EN undefined: no counter; a missing rply holds DATA indefinitely.
// TESTING
//  1. DATI addr 0o177560, slave rply after 3 clk with data 0x00A5 -> sync/din sequence, rdata=0x00A5, ack, err=0.
//  2. DATOB addr 0o001001 wdata 0x5A00 -> wtbt=1 in DATA, ad_o=0x5A00, dout until rply, ack.
//  3. DATIO addr 0o000100: read 0x1234 then write 0x4321 -> sync held high across both phases, single ack, rdata=0x1234.
//  4. dmr and req raised on same edge -> dmgo=1; sack 10 clk; then the DATI runs and acks.
//  5. MPI_TIMEOUT_EN, TMO_CYC=8, no rply -> strobes drop after 8 clk in DATA, ack+err=1; without the macro, still in DATA at clk 1000.
//  6. rst_n low during DATA of DATO -> next edge sync=dout=ad_oe=0, no ack; req_op=111 -> ack+err 1 clk later.

Source files
------------

// File: rtl/mpi_bus_master.sv
// MPI bus cycle sequencer: DATI/DATO/DATOB/DATIO/IAK cycles with DMR/DMGO/SACK DMA arbitration.
// Optional RPLY timeout: define MPI_TIMEOUT_EN to enable the TMO_CYC watchdog.
module mpi_bus_master #(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int SETUP   = 1,
    parameter int TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [2:0]    req_op,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          ack,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic [DW-1:0] ad_o,
    output logic          ad_oe,
    input  logic [DW-1:0] ad_i,
    output logic          sync,
    output logic          din,
    output logic          dout,
    output logic          wtbt,
    output logic          iako,
    input  logic          rply,
    input  logic          dmr,
    input  logic          sack,
    output logic          dmgo
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_SYNC, S_DATA, S_RWAIT, S_END, S_DGNT, S_DMA
    } state_t;

    localparam logic [2:0] OP_DATI  = 3'b000;
    localparam logic [2:0] OP_DATO  = 3'b001;
    localparam logic [2:0] OP_DATOB = 3'b010;
    localparam logic [2:0] OP_DATIO = 3'b011;
    localparam logic [2:0] OP_IAK   = 3'b100;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    setup_q, setup_d;
    logic          wr_phase_q, wr_phase_d;
    logic          armed_q, armed_d;
    logic          pulse_q, pulse_d;
    logic          perr_q, perr_d;

    logic op_legal;
    logic read_phase;
    logic wr_op;
    logic tmo_hit;

    assign op_legal   = (req_op <= OP_IAK);
    assign wr_op      = (op_q == OP_DATO) || (op_q == OP_DATOB) || (op_q == OP_DATIO);
    assign read_phase = (op_q == OP_DATI) || (op_q == OP_IAK) ||
                        ((op_q == OP_DATIO) && !wr_phase_q);

`ifdef MPI_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    assign tmo_hit = ((state_q == S_DATA) || (state_q == S_RWAIT)) &&
                     ((tmo_q + 16'd1) == 16'(TMO_CYC));

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == S_DATA) || (state_q == S_RWAIT)) tmo_d = tmo_q + 16'd1;
        if ((state_q == S_SYNC) || ((state_q == S_RWAIT) && (state_d == S_DATA))) tmo_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) tmo_q <= '0;
        else        tmo_q <= tmo_d;
    end
`else
    logic unused_tmo;

    assign tmo_hit    = 1'b0;
    assign unused_tmo = (TMO_CYC == 0);
`endif

    // NOTE: every variable gets its hold value before the case, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        setup_d    = setup_q;
        wr_phase_d = wr_phase_q;
        armed_d    = armed_q;
        pulse_d    = 1'b0;
        perr_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dmr) begin
                    state_d = S_DGNT;
                end else if (req && !pulse_q) begin
                    if (op_legal) begin
                        state_d    = S_ADDR;
                        op_d       = req_op;
                        addr_d     = req_addr;
                        wdata_d    = req_wdata;
                        setup_d    = '0;
                        wr_phase_d = 1'b0;
                    end else begin
                        pulse_d = 1'b1;
                        perr_d  = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (setup_q == 4'(SETUP - 1)) state_d = S_SYNC;
                else                          setup_d = setup_q + 4'd1;
            end
            S_SYNC: begin
                state_d = S_DATA;
                armed_d = !rply;   // a reply already high here is stale
            end
            S_DATA: begin
                armed_d = armed_q | !rply;
                if (rply && armed_q) begin
                    state_d = S_RWAIT;
                    if (read_phase) rdata_d = ad_i;
                end
            end
            S_RWAIT: begin
                if (!rply) begin
                    if ((op_q == OP_DATIO) && !wr_phase_q) begin
                        state_d    = S_DATA;
                        wr_phase_d = 1'b1;
                        armed_d    = 1'b1;
                    end else begin
                        state_d = S_END;
                    end
                end
            end
            S_END:   state_d = S_IDLE;
            S_DGNT:  if (sack)  state_d = S_DMA;
            S_DMA:   if (!sack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (tmo_hit) begin
            state_d = S_IDLE;
            rdata_d = rdata_q;
            pulse_d = 1'b1;
            perr_d  = 1'b1;
        end
    end

    always_comb begin
        ack   = 1'b0;
        err   = 1'b0;
        ad_o  = '0;
        ad_oe = 1'b0;
        sync  = 1'b0;
        din   = 1'b0;
        dout  = 1'b0;
        wtbt  = 1'b0;
        iako  = 1'b0;
        dmgo  = 1'b0;

        case (state_q)
            S_IDLE: begin
                ack = pulse_q;
                err = perr_q;
            end
            S_ADDR, S_SYNC: begin
                ad_oe = 1'b1;
                ad_o  = (op_q == OP_IAK) ? '0 : DW'(addr_q);
                wtbt  = wr_op;
                sync  = (state_q == S_SYNC);
            end
            S_DATA: begin
                sync = 1'b1;
                if (read_phase) begin
                    din  = 1'b1;
                    iako = (op_q == OP_IAK);
                end else begin
                    ad_oe = 1'b1;
                    ad_o  = wdata_q;
                    dout  = 1'b1;
                    wtbt  = (op_q == OP_DATOB);
                end
            end
            S_RWAIT: begin
                sync = 1'b1;
                if (!read_phase) begin
                    ad_oe = 1'b1;
                    ad_o  = wdata_q;
                end
            end
            S_END:   ack  = 1'b1;
            S_DGNT:  dmgo = 1'b1;
            default: ;
        endcase
    end

    assign rdata = rdata_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            setup_q    <= '0;
            wr_phase_q <= 1'b0;
            armed_q    <= 1'b0;
            pulse_q    <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            setup_q    <= setup_d;
            wr_phase_q <= wr_phase_d;
            armed_q    <= armed_d;
            pulse_q    <= pulse_d;
            perr_q     <= perr_d;
        end
    end

endmodule

// File: tb/tb_mpi_bus_master.sv
// Self-checking bench for mpi_bus_master: directed table, randomized cycles against a cycle-count model,
// and hand sequences for DMA, stale reply, reset mid-cycle and RPLY timeout.
module tb_mpi_bus_master;

    localparam int AW = 16, DW = 16, SETUP_P = 1, TMO_P = 8, BUDGET = 200;
    localparam logic [2:0] OP_DATI = 3'd0, OP_DATO = 3'd1, OP_DATOB = 3'd2, OP_DATIO = 3'd3, OP_IAK = 3'd4;

    logic          clk = 1'b0;
    logic          rst_n, req, ack, err, ad_oe, sync, din, dout, wtbt, iako, rply, dmr, sack, dmgo;
    logic [2:0]    req_op;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata, rdata, ad_o, ad_i;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] model_rdata;

    mpi_bus_master #(.AW(AW), .DW(DW), .SETUP(SETUP_P), .TMO_CYC(TMO_P)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .ack(ack), .err(err), .rdata(rdata), .ad_o(ad_o),
        .ad_oe(ad_oe), .ad_i(ad_i), .sync(sync), .din(din), .dout(dout), .wtbt(wtbt),
        .iako(iako), .rply(rply), .dmr(dmr), .sack(sack), .dmgo(dmgo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] sdata;
        int          d1;
        int          d2;
        int          exp_lat;
        logic        exp_err;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        int          lat;
        logic        err;
        logic [15:0] rdata;
        logic        legal;
        int          n_sync, n_din, n_dout, n_iako;
        logic [15:0] addr;
        logic        wtbt_a, wtbt_d;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cycle budget of a bus cycle: SETUP address cycles, one SYNC cycle, reply wait, RWAIT, END.
    function automatic exp_t model(input vec_t v, input logic [15:0] prev);
        exp_t e;
        logic rd, wr;
        rd = (v.op == OP_DATI) || (v.op == OP_IAK) || (v.op == OP_DATIO);
        wr = (v.op == OP_DATO) || (v.op == OP_DATOB) || (v.op == OP_DATIO);
        e.legal = (v.op <= OP_IAK);
        if (!e.legal) begin
            e.lat = 1; e.err = 1'b1; e.rdata = prev;
            e.n_sync = 0; e.n_din = 0; e.n_dout = 0; e.n_iako = 0;
            e.addr = '0; e.wtbt_a = 1'b0; e.wtbt_d = 1'b0;
        end else begin
            e.lat    = SETUP_P + 4 + v.d1 + ((v.op == OP_DATIO) ? v.d2 + 2 : 0);
            e.err    = 1'b0;
            e.rdata  = rd ? v.sdata : prev;
            e.n_sync = e.lat - SETUP_P - 1;
            e.n_din  = rd ? v.d1 + 1 : 0;
            e.n_dout = (v.op == OP_DATIO) ? v.d2 + 1 : (wr ? v.d1 + 1 : 0);
            e.n_iako = (v.op == OP_IAK) ? v.d1 + 1 : 0;
            e.addr   = (v.op == OP_IAK) ? 16'h0000 : v.addr;
            e.wtbt_a = wr;
            e.wtbt_d = (v.op == OP_DATOB);
        end
        return e;
    endfunction

    // Drives one request, plays the slave (reply after d cycles of DIN/DOUT), and checks the cycle.
    task automatic run_txn(input vec_t v, input bit pre, input string tag);
        exp_t        e;
        int          lat, st, rep, n_sync, n_din, n_dout, n_iako, breaks, bad;
        bit          a_seen, s_seen, prev_sync;
        logic [15:0] addr_a, addr_s, got_rdata;
        logic        wtbt_a_got, got_err;
        e = model(v, model_rdata);
        lat = -1; st = 0; rep = 0; n_sync = 0; n_din = 0; n_dout = 0; n_iako = 0; breaks = 0; bad = 0;
        a_seen = 0; s_seen = 0; prev_sync = 0; addr_a = '0; addr_s = '0; wtbt_a_got = 0;
        got_err = 0; got_rdata = '0;
        if (!pre) begin
            @(negedge clk);
            req = 1'b1; req_op = v.op; req_addr = v.addr; req_wdata = v.wdata;
        end
        for (int i = 0; i < BUDGET && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sync) begin
                n_sync++;
                if (s_seen && !prev_sync) breaks++;
                if (!s_seen) begin
                    s_seen = 1; addr_s = ad_o;
                    if (!ad_oe) bad++;
                end
            end
            prev_sync = sync;
            if (ad_oe && !sync && !a_seen) begin
                a_seen = 1; addr_a = ad_o; wtbt_a_got = wtbt;
            end
            if (din) begin
                n_din++;
                if (ad_oe || dout) bad++;
            end
            if (dout) begin
                n_dout++;
                if (!ad_oe || ad_o !== v.wdata || wtbt !== e.wtbt_d) bad++;
            end
            if (iako) n_iako++;
            if (ack) begin
                lat = i + 1; got_err = err; got_rdata = rdata; req = 1'b0;
            end
            if (!rply && (din || dout)) begin
                st++;
                if (st > ((rep == 0) ? v.d1 : v.d2)) begin
                    rply = 1'b1;
                    if (din) ad_i = v.sdata;
                end
            end else if (rply && !din && !dout) begin
                rply = 1'b0; rep++; st = 0; ad_i = 16'($urandom);
            end
        end
        req = 1'b0;
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " err"}, got_err, v.exp_err);
        check({tag, " rdata"}, got_rdata, v.exp_rdata);
        check({tag, " sync cycles"}, n_sync, e.n_sync);
        check({tag, " din cycles"}, n_din, e.n_din);
        check({tag, " dout cycles"}, n_dout, e.n_dout);
        check({tag, " iako cycles"}, n_iako, e.n_iako);
        check({tag, " sync breaks"}, breaks, 0);
        check({tag, " bad data phase"}, bad, 0);
        check({tag, " addr phase seen"}, a_seen, e.legal);
        if (a_seen) begin
            check({tag, " addr phase ad_o"}, addr_a, e.addr);
            check({tag, " addr phase wtbt"}, wtbt_a_got, e.wtbt_a);
        end
        if (s_seen) check({tag, " addr at sync"}, addr_s, e.addr);
        model_rdata = v.exp_rdata;
    endtask

    initial begin
        vec_t        tbl[9];
        vec_t        v;
        exp_t        e;
        int          busy, nd, lat;
        bit          seen;
        logic        got_err, strobes;
        logic [15:0] got_rdata;

        tbl[0] = '{OP_DATI,  16'hFF70, 16'h0000, 16'h00A5, 3, 0,  8, 1'b0, 16'h00A5};
        tbl[1] = '{OP_DATOB, 16'h0201, 16'h5A00, 16'h0000, 1, 0,  6, 1'b0, 16'h00A5};
        tbl[2] = '{OP_DATIO, 16'h0040, 16'h4321, 16'h1234, 0, 0,  7, 1'b0, 16'h1234};
        tbl[3] = '{OP_IAK,   16'h1FFF, 16'h0000, 16'h0030, 0, 0,  5, 1'b0, 16'h0030};
        tbl[4] = '{OP_DATO,  16'hFFFF, 16'hFFFF, 16'h0000, 2, 0,  7, 1'b0, 16'h0030};
        tbl[5] = '{3'b111,   16'h0000, 16'h0000, 16'h0000, 0, 0,  1, 1'b1, 16'h0030};
        tbl[6] = '{3'b101,   16'h1234, 16'h0000, 16'h0000, 0, 0,  1, 1'b1, 16'h0030};
        tbl[7] = '{OP_DATIO, 16'h8001, 16'h0001, 16'hBEEF, 2, 1, 10, 1'b0, 16'hBEEF};
        tbl[8] = '{OP_DATI,  16'h0002, 16'h0000, 16'h0000, 0, 0,  5, 1'b0, 16'h0000};

        rst_n = 1'b0; req = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
        ad_i = '0; rply = 1'b0; dmr = 1'b0; sack = 1'b0;
        model_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sync", sync, 0);
        check("reset din", din, 0);
        check("reset dout", dout, 0);
        check("reset wtbt", wtbt, 0);
        check("reset iako", iako, 0);
        check("reset ack", ack, 0);
        check("reset err", err, 0);
        check("reset ad_oe", ad_oe, 0);
        check("reset ad_o", ad_o, 0);
        check("reset dmgo", dmgo, 0);
        check("reset rdata", rdata, 0);
        rst_n = 1'b1;

        for (int k = 0; k < 9; k++) run_txn(tbl[k], 0, $sformatf("vec%0d", k));

        for (int k = 0; k < 40; k++) begin
            v.op    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            v.addr  = 16'($urandom);
            v.wdata = 16'($urandom);
            v.sdata = 16'($urandom);
            v.d1    = $urandom_range(0, 4);
            v.d2    = $urandom_range(0, 4);
            e = model(v, model_rdata);
            v.exp_lat = e.lat; v.exp_err = e.err; v.exp_rdata = e.rdata;
            run_txn(v, 0, $sformatf("rand%0d", k));
        end

        // DMA request wins over a simultaneous bus request, which then runs once SACK drops.
        @(negedge clk);
        dmr = 1'b1; req = 1'b1; req_op = OP_DATI; req_addr = 16'h0100;
        @(posedge clk);
        @(negedge clk);
        check("dma dmgo", dmgo, 1);
        check("dma no sync", sync, 0);
        check("dma no ad_oe", ad_oe, 0);
        sack = 1'b1; dmr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("dma dmgo released", dmgo, 0);
        busy = 0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            if (sync || ad_oe || ack || dmgo || din || dout) busy++;
        end
        check("dma bus released", busy, 0);
        sack = 1'b0;
        v = '{OP_DATI, 16'h0100, 16'h0000, 16'hC3C3, 0, 0, 6, 1'b0, 16'hC3C3};
        run_txn(v, 1, "dma_dati");

        // A reply still high when DATA starts must be seen low before it counts.
        @(negedge clk);
        rply = 1'b1; ad_i = 16'hDEAD; req = 1'b1; req_op = OP_DATI; req_addr = 16'h0200;
        nd = 0; lat = -1; got_err = 1'b0; got_rdata = '0;
        for (int i = 0; i < 50 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (din) nd++;
            if (ack) begin
                lat = i + 1; got_err = err; got_rdata = rdata; req = 1'b0;
            end
            if (din && nd == 3) rply = 1'b0;
            else if (din && nd == 4 && !rply) begin
                rply = 1'b1; ad_i = 16'h7777;
            end else if (!din && rply && nd >= 4) begin
                rply = 1'b0; ad_i = 16'hDEAD;
            end
        end
        req = 1'b0; rply = 1'b0;
        check("stale rply latency", lat, 8);
        check("stale rply din cycles", nd, 4);
        check("stale rply rdata", got_rdata, 16'h7777);
        check("stale rply err", got_err, 0);
        model_rdata = 16'h7777;

        // Reset in the middle of a DATO data phase.
        @(negedge clk);
        req = 1'b1; req_op = OP_DATO; req_addr = 16'h0400; req_wdata = 16'h1111;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (dout) seen = 1;
        end
        check("rst dout reached", seen, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst sync dropped", sync, 0);
        check("rst dout dropped", dout, 0);
        check("rst ad_oe dropped", ad_oe, 0);
        check("rst no ack", ack, 0);
        check("rst rdata cleared", rdata, 0);
        rst_n = 1'b1; req = 1'b0; busy = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (ack || sync) busy++;
        end
        check("post rst quiet", busy, 0);
        model_rdata = '0;
        v = '{3'b111, 16'h0000, 16'h0000, 16'h0000, 0, 0, 1, 1'b1, 16'h0000};
        run_txn(v, 0, "ill_after_rst");

        // Missing reply.
        @(negedge clk);
        req = 1'b1; req_op = OP_DATI; req_addr = 16'h0300; rply = 1'b0;
`ifdef MPI_TIMEOUT_EN
        nd = 0; lat = -1; got_err = 1'b0; got_rdata = '0; strobes = 1'b1;
        for (int i = 0; i < 100 && lat < 0; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (din) nd++;
            if (ack) begin
                lat = i + 1; got_err = err; got_rdata = rdata;
                strobes = sync | din | ad_oe; req = 1'b0;
            end
        end
        req = 1'b0;
        check("tmo latency", lat, SETUP_P + 2 + TMO_P);
        check("tmo err", got_err, 1);
        check("tmo rdata held", got_rdata, model_rdata);
        check("tmo din cycles", nd, TMO_P);
        check("tmo strobes dropped", strobes, 0);
`else
        busy = 0;
        repeat (1000) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) busy++;
        end
        check("no tmo din held", din, 1);
        check("no tmo sync held", sync, 1);
        check("no tmo no ack", busy, 0);
        rst_n = 1'b0; req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("no tmo reset recovers", sync, 0);
        strobes = 1'b0; got_err = 1'b0; got_rdata = '0; lat = 0; nd = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
